// File: rtl/addsub_pipe.sv
// Pipelined two's-complement add/sub: one CHUNK-bit slice resolved per stage, carry rippling between stages.
// Latency STAGES cycles, one op per cycle; a stalled output freezes the whole pipe and drops in_ready.
module addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int CHUNK  = 4,
  parameter int STAGES = WIDTH / CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   s,
  output logic             ovf
);

  localparam int LAST = STAGES - 1;

  logic              en;
  logic              rdy_q;
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  r_q [STAGES];
  logic [WIDTH-1:0]  r_d [STAGES];

  assign en        = !vld_q[LAST] || out_ready;
  // rdy_q keeps in_ready low through reset and for the first edge after it
  assign in_ready  = rdy_q && en;
  assign out_valid = vld_q[LAST];
  assign s         = {c_q[LAST], r_q[LAST]};
  assign ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                     (r_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

  always_comb begin
    logic [CHUNK:0] sl;
    sl = '0;
    // Subtraction is folded into the operands up front: B' = ~y, carry = !cin
    a_d[0]   = x;
    b_d[0]   = sub ? ~y : y;
    sl       = {1'b0, x[CHUNK-1:0]} + {1'b0, b_d[0][CHUNK-1:0]} + {{CHUNK{1'b0}}, sub ^ cin};
    r_d[0]   = '0;
    r_d[0][CHUNK-1:0] = sl[CHUNK-1:0];
    c_d[0]   = sl[CHUNK];
    vld_d[0] = in_valid && in_ready;
    for (int k = 1; k < STAGES; k++) begin
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
      r_d[k] = r_q[k-1];
      sl     = {1'b0, a_q[k-1][k*CHUNK +: CHUNK]} + {1'b0, b_q[k-1][k*CHUNK +: CHUNK]} +
               {{CHUNK{1'b0}}, c_q[k-1]};
      r_d[k][k*CHUNK +: CHUNK] = sl[CHUNK-1:0];
      c_d[k]   = sl[CHUNK];
      vld_d[k] = vld_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q <= 1'b0;
      vld_q <= '0;
      c_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
    end else begin
      rdy_q <= 1'b1;
      if (en) begin
        vld_q <= vld_d;
        c_q   <= c_d;
        for (int k = 0; k < STAGES; k++) begin
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
          r_q[k] <= r_d[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe at 16/4, 8/8 and 32/4 with directed vectors and a scoreboarded random stream.
module tb_addsub_pipe;

  logic        clk, rst_n;
  logic        ivg [3];
  logic        org [3];
  logic        sbg [3];
  logic        cig [3];
  logic [31:0] xg  [3];
  logic [31:0] yg  [3];
  logic        irg [3];
  logic        ovg [3];
  logic        ofg [3];
  logic [32:0] sg  [3];

  logic        ir0, ir1, ir2, ov0, ov1, ov2, of0, of1, of2;
  logic [16:0] s0;
  logic [8:0]  s1;
  logic [32:0] s2;

  addsub_pipe #(.WIDTH(16), .CHUNK(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivg[0]), .in_ready(ir0), .x(xg[0][15:0]), .y(yg[0][15:0]),
    .sub(sbg[0]), .cin(cig[0]), .out_valid(ov0), .out_ready(org[0]), .s(s0), .ovf(of0));
  addsub_pipe #(.WIDTH(8), .CHUNK(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivg[1]), .in_ready(ir1), .x(xg[1][7:0]), .y(yg[1][7:0]),
    .sub(sbg[1]), .cin(cig[1]), .out_valid(ov1), .out_ready(org[1]), .s(s1), .ovf(of1));
  addsub_pipe #(.WIDTH(32), .CHUNK(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivg[2]), .in_ready(ir2), .x(xg[2]), .y(yg[2]),
    .sub(sbg[2]), .cin(cig[2]), .out_valid(ov2), .out_ready(org[2]), .s(s2), .ovf(of2));

  always_comb begin
    irg[0] = ir0; irg[1] = ir1; irg[2] = ir2;
    ovg[0] = ov0; ovg[1] = ov1; ovg[2] = ov2;
    ofg[0] = of0; ofg[1] = of1; ofg[2] = of2;
    sg[0]  = {16'b0, s0};
    sg[1]  = {24'b0, s1};
    sg[2]  = s2;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int wdt [3] = '{16, 8, 32};
  int lat [3] = '{4, 1, 8};
  int wr [3], rd [3], cyc [3], first_acc [3], first_out [3], last_out [3];
  logic hold [3];
  logic [33:0] sbq [3][0:63];

  typedef struct {
    logic        sub;
    logic        cin;
    logic [15:0] x;
    logic [15:0] y;
    logic [16:0] s;
    logic        ovf;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: unsigned arithmetic for the carry, signed range test for overflow
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic is_sub, input logic c);
    longint mask, half, ua, ub, lc, full, sa, sbv, res;
    logic carry, ov;
    logic [32:0] sres;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'({32'b0, a}) & mask;
    ub   = longint'({32'b0, b}) & mask;
    lc   = c ? 1 : 0;
    if (is_sub) begin
      full  = ua - ub - lc;
      carry = (full >= 0);
    end else begin
      full  = ua + ub + lc;
      carry = ((full >> w) & 1) != 0;
    end
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sbv  = (ub >= half) ? ub - 2 * half : ub;
    res  = is_sub ? sa - sbv - lc : sa + sbv + lc;
    ov   = (res >= half) || (res < -half);
    sres = 33'((carry ? (longint'(1) << w) : longint'(0)) | (full & mask));
    return {ov, sres};
  endfunction

  task automatic step(input int d, input logic want_iv, input logic want_or);
    logic [33:0] e;
    @(posedge clk); #1;
    if (!hold[d]) begin
      xg[d]  = $urandom;
      yg[d]  = $urandom;
      sbg[d] = 1'($urandom);
      cig[d] = 1'($urandom);
      ivg[d] = want_iv;
    end
    org[d] = want_or;
    @(negedge clk);
    cyc[d]++;
    if (ivg[d] && irg[d]) begin
      sbq[d][wr[d] % 64] = model(wdt[d], xg[d], yg[d], sbg[d], cig[d]);
      wr[d]++;
      if (first_acc[d] < 0) first_acc[d] = cyc[d];
    end
    hold[d] = ivg[d] && !irg[d];
    if (ovg[d] && org[d]) begin
      if (wr[d] == rd[d]) begin
        chk($sformatf("unexpected_out_d%0d", d), 64'(ovg[d]), 64'd0);
      end else begin
        e = sbq[d][rd[d] % 64];
        rd[d]++;
        chk($sformatf("res_s_d%0d", d), 64'(sg[d]), 64'(e[32:0]));
        chk($sformatf("res_ovf_d%0d", d), 64'(ofg[d]), 64'(e[33]));
      end
      if (first_out[d] < 0) first_out[d] = cyc[d];
      last_out[d] = cyc[d];
    end
  endtask

  task automatic drain(input int d);
    int k;
    k = 0;
    while ((wr[d] != rd[d] || ovg[d] || hold[d]) && k < 60) begin
      step(d, 1'b0, 1'b1);
      k++;
    end
    chk($sformatf("drain_left_d%0d", d), 64'(wr[d] - rd[d]), 64'd0);
    chk($sformatf("drain_vld_d%0d", d), 64'(ovg[d]), 64'd0);
  endtask

  task automatic tput(input int d, input int n);
    int rd0;
    rd0 = rd[d];
    first_acc[d] = -1;
    first_out[d] = -1;
    for (int i = 0; i < n; i++) step(d, 1'b1, 1'b1);
    drain(d);
    chk($sformatf("tp_latency_d%0d", d), 64'(first_out[d] - first_acc[d]), 64'(lat[d]));
    chk($sformatf("tp_span_d%0d", d), 64'(last_out[d] - first_out[d]), 64'(n - 1));
    chk($sformatf("tp_count_d%0d", d), 64'(rd[d] - rd0), 64'(n));
  endtask

  task automatic rand_run(input int d, input int nops);
    int target, k;
    target = wr[d] + nops;
    k = 0;
    while (wr[d] < target && k < nops * 10) begin
      step(d, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      k++;
    end
    chk($sformatf("rand_ops_d%0d", d), 64'(wr[d] >= target), 64'd1);
    drain(d);
  endtask

  task automatic directed(input vec_t v);
    int k;
    logic done;
    @(posedge clk); #1;
    ivg[0] = 1'b1; org[0] = 1'b1;
    xg[0] = {16'b0, v.x}; yg[0] = {16'b0, v.y}; sbg[0] = v.sub; cig[0] = v.cin;
    @(negedge clk);
    chk("dir_in_ready", 64'(irg[0]), 64'd1);
    k = 0;
    done = 1'b0;
    while (!done && k < 20) begin
      @(posedge clk);
      k++;
      #1 ivg[0] = 1'b0;
      @(negedge clk);
      if (ovg[0]) done = 1'b1;
    end
    chk("dir_latency", 64'(k), 64'd4);
    chk("dir_s", 64'(sg[0]), 64'(v.s));
    chk("dir_ovf", 64'(ofg[0]), 64'(v.ovf));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] hs;
    logic        ho;
    int          k;
    tbl[0] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 17'h10000, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 16'h1234, 16'h1111, 17'h02346, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 17'h08000, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 16'h8000, 16'h0001, 17'h17FFF, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 16'h0003, 16'h0005, 17'h0FFFE, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 16'h0005, 16'h0003, 17'h10001, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 16'h8000, 16'h8000, 17'h10000, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 17'h10000, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 16'h7FFF, 16'hFFFF, 17'h08000, 1'b1};

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      ivg[d] = 1'b0; org[d] = 1'b0; sbg[d] = 1'b0; cig[d] = 1'b0;
      xg[d] = '0; yg[d] = '0; hold[d] = 1'b0;
      wr[d] = 0; rd[d] = 0; cyc[d] = 0; first_acc[d] = -1; first_out[d] = -1; last_out[d] = 0;
    end
    #12;
    chk("rst_out_valid", 64'(ovg[0]), 64'd0);
    chk("rst_in_ready", 64'(irg[0]), 64'd0);
    chk("rst_s", 64'(sg[0]), 64'd0);
    chk("rst_ovf", 64'(ofg[0]), 64'd0);
    #10 rst_n = 1'b1;
    #2 chk("rdy_before_edge", 64'(irg[0]), 64'd0);
    @(negedge clk);
    chk("rdy_after_edge", 64'(irg[0]), 64'd1);

    for (int i = 0; i < 9; i++) directed(tbl[i]);
    @(posedge clk); #1;

    tput(0, 100);

    // Stall: fill with out_ready low and check the frozen output
    k = 0;
    while (!ovg[0] && k < 20) begin
      step(0, 1'b1, 1'b0);
      k++;
    end
    chk("stall_reach", 64'(ovg[0]), 64'd1);
    chk("stall_in_ready", 64'(irg[0]), 64'd0);
    hs = sg[0];
    ho = ofg[0];
    for (int i = 0; i < 5; i++) begin
      step(0, 1'b1, 1'b0);
      chk("stall_vld", 64'(ovg[0]), 64'd1);
      chk("stall_s", 64'(sg[0]), 64'(hs));
      chk("stall_ovf", 64'(ofg[0]), 64'(ho));
    end
    for (int i = 0; i < 30; i++) step(0, 1'(($urandom_range(0, 3)) != 0), 1'b1);
    drain(0);

    rand_run(0, 1000);

    // Reset with several ops in flight and the output stalled
    k = 0;
    while (!ovg[0] && k < 20) begin
      step(0, 1'b1, 1'b0);
      k++;
    end
    chk("mid_reach", 64'(ovg[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 64'(ovg[0]), 64'd0);
    chk("mid_rst_rdy", 64'(irg[0]), 64'd0);
    chk("mid_rst_s", 64'(sg[0]), 64'd0);
    wr[0] = rd[0];
    hold[0] = 1'b0;
    ivg[0] = 1'b0;
    org[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1 chk("mid_rdy_low", 64'(irg[0]), 64'd0);
    @(negedge clk);
    chk("mid_rdy_high", 64'(irg[0]), 64'd1);
    chk("mid_vld_low", 64'(ovg[0]), 64'd0);
    for (int i = 0; i < 20; i++) step(0, 1'b1, 1'($urandom_range(0, 1)));
    drain(0);

    tput(1, 50);
    rand_run(1, 300);
    tput(2, 50);
    rand_run(2, 300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined two's-complement adder/subtractor with carry/borrow-in, carry-out and signed-overflow flags.
- Carry ripples one CHUNK-bit slice per clock, so WIDTH scales without lengthening the critical path.
- Valid/ready handshakes on input and output; full throughput of one operation per cycle.
- Arithmetic building block for datapaths wider than a single-cycle ripple adder can close timing on.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK and at least CHUNK.
- CHUNK, 4, bits resolved per pipeline stage.
- STAGES, WIDTH/CHUNK, derived; pipeline depth and latency in cycles. Do not override.

Ports:
- clk        input   1        rising-edge clock
- rst_n      input   1        reset, asynchronous assert, active-low
- in_valid   input   1        operation presented this cycle
- in_ready   output  1        block accepts an operation this cycle
- x          input   WIDTH    operand A
- y          input   WIDTH    operand B
- sub        input   1        0: x+y+cin; 1: x-y-cin
- cin        input   1        carry-in (add) or borrow-in (sub)
- out_valid  output  1        result valid
- out_ready  input   1        consumer accepts the result
- s          output  WIDTH+1  s[WIDTH-1:0] is the result; s[WIDTH] is the carry-out, which for sub means no-borrow
- ovf        output  1        signed overflow of the WIDTH-bit result

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n).
  - While rst_n=0, all stage valid bits, s, ovf and out_valid are 0.
  - in_ready is 1 one cycle after rst_n deasserts; it is 0 during reset.
- Arithmetic:
  - Add: x + y + cin.
  - Sub: x + ~y + !cin, which equals x - y - cin.
  - ovf = (A[W-1]==B'[W-1]) && (R[W-1]!=A[W-1]), where B' is y or ~y per sub, and R is the WIDTH-bit result.
  - Results are mod 2^WIDTH, with carry in s[WIDTH].
- Pipeline:
  - Stage k (0..STAGES-1) registers slice k of the sum using the carry from stage k-1. Stage 0 uses the effective carry-in.
  - The higher, not-yet-summed operand slices and the sub bit travel forward with each stage, skewed in registers.
  - Stage k holds low slices 0..k complete.
  - Each stage has a valid bit; out_valid is the last stage's valid bit.
- Latency: an operation accepted on cycle n (in_valid && in_ready) appears with out_valid=1 on cycle n+STAGES when there is no stall.
- Flow control:
  - Global enable: en = !out_valid || out_ready; in_ready = en.
  - When en=1, every stage advances, including bubbles.
  - When en=0, every stage holds and s/ovf stay stable.
  - Bubbles are not collapsed.
- Input side:
  - in_valid && !in_ready: nothing is accepted; the source must hold its data.
  - in_valid=0 with en=1: a bubble (valid=0) enters stage 0.
- Output side: s and ovf change only when the last stage is loaded. Their value while out_valid=0 is don't-care, but they must not be X after reset.
- Simultaneous events: out_ready=1 with out_valid=1 and in_valid=1 in the same cycle retires one result and accepts one operation. This sustains 1 op/cycle.
- Reset mid-operation: all in-flight operations are discarded. No result for them is ever presented.
- STAGES=1 (CHUNK=WIDTH): the block degenerates to a single registered add with the same handshake.

Test Plan (WIDTH=16, CHUNK=4, latency 4):
- Add carry-out: x=0xFFFF, y=0x0001, sub=0, cin=0 -> 4 cycles later s=0x10000, ovf=0; x=0x1234, y=0x1111, cin=1 -> s=0x02346, ovf=0.
- Signed overflow:
  - Add 0x7FFF+0x0001 -> s=0x08000, ovf=1.
  - Sub 0x8000-0x0001 (cin=0) -> s=0x17FFF, ovf=1.
  - Sub 0x0003-0x0005 -> s=0x0FFFE (s[16]=0 borrow), ovf=0.
  - Sub 0x0005-0x0003 with cin=1 -> s=0x10001.
- Throughput: 100 random back-to-back ops, in_valid and out_ready held 1 -> one result per cycle in order, each matching the reference model, first result 4 cycles after the first accept.
- Backpressure:
  - Hold out_ready=0 while out_valid=1 -> in_ready=0 the same cycle; s and ovf are stable for 5 cycles.
  - Release -> stream resumes with no loss or duplication.
  - Random in_valid/out_ready over 1000 ops -> exact in-order match.
- Reset mid-stream: assert rst_n=0 asynchronously with 3 ops in flight -> out_valid=0 immediately; after release, only post-reset ops appear.
- Parameter sweep: repeat the random test at WIDTH=8/CHUNK=8 (latency 1) and WIDTH=32/CHUNK=4 (latency 8).
